// File: rtl/instr_fetch_unit.sv
// Instruction fetch bus master for the multicycle MIPS core: issues one Avalon
// word read per request, delivers the word to the IR and flags misalignment/timeouts.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic [31:0] fetch_pc,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] mem_input,
  output logic        IRWrite,
  output logic        fetch_busy,
  output logic        fetch_err
);

  // A zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT_CYCLES == 32'd0) ? 1 : $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : (TIMEOUT_CYCLES - 32'd1));
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_avm_address;
  logic [31:0]       w_avm_address_nxt;
  logic              r_avm_read;
  logic              w_avm_read_nxt;
  logic [31:0]       r_mem_input;
  logic [31:0]       w_mem_input_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_irwrite;
  logic              r_busy;
  logic              r_err;

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt       = r_state;
    w_avm_address_nxt = r_avm_address;
    w_avm_read_nxt    = r_avm_read;
    w_mem_input_nxt   = r_mem_input;
    w_cnt_nxt         = r_cnt;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (fetch_start) begin
          if (fetch_pc[1:0] != 2'b00) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt       = S_WAIT;
            w_avm_address_nxt = fetch_pc;
            w_avm_read_nxt    = 1'b1;
            w_cnt_nxt         = {CNT_W{1'b0}};
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_WAIT: begin
        if (!avm_waitrequest) begin
          w_state_nxt     = S_DELIVER;
          w_mem_input_nxt = avm_readdata;
          w_avm_read_nxt  = 1'b0;
        end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
          w_state_nxt    = S_ERR;
          w_avm_read_nxt = 1'b0;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_DELIVER: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_avm_read_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_avm_address <= RESET_VECTOR;
      r_avm_read    <= 1'b0;
      r_mem_input   <= 32'h0000_0000;
      r_cnt         <= {CNT_W{1'b0}};
      r_irwrite     <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_avm_address <= w_avm_address_nxt;
      r_avm_read    <= w_avm_read_nxt;
      r_mem_input   <= w_mem_input_nxt;
      r_cnt         <= w_cnt_nxt;
      r_irwrite     <= (w_state_nxt == S_DELIVER);
      r_busy        <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_DELIVER);
      r_err         <= (w_state_nxt == S_ERR);
    end
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign mem_input   = r_mem_input;
  assign IRWrite     = r_irwrite;
  assign fetch_busy  = r_busy;
  assign fetch_err   = r_err;

endmodule
